// File: rtl/deserializer_out.sv
// deserializer_out
// Receive stage for the 1-bit serial line: recovers 9-bit {k, byte} symbols,
// aligns on the comma symbol and rebuilds each comma-delimited group of three
// data symbols into one 27-bit word presented with a one-cycle valid strobe.
module deserializer_out #(
  parameter logic [8:0] COMMA_SYM   = 9'h13C,
  parameter int         LOCK_COMMAS = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_i,
  output logic [26:0] data_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_DATA  = 2'd2,
    ST_SYNC  = 2'd3
  } state_t;

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_COMMAS);

  state_t     state_reg;
  // Holds sr[8:1]; sr[0] is always shifted out on the next bit, so it is not kept.
  logic [7:0] sr_reg;
  logic [8:0] sr_next;
  logic [3:0] bcnt_reg;
  logic [3:0] bcnt_next;
  logic [1:0] wcnt_reg;
  logic [2:0] ccnt_reg;
  logic [2:0] ccnt_next;
  logic [8:0] w0_reg;
  logic [8:0] w1_reg;
  logic       boundary;
  logic       is_comma;
  logic       is_k;

  // Newest bit enters at the top; the symbol arrives LSB first with k last.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign sr_next[gi] = sr_reg[gi];
    end
  endgenerate
  assign sr_next[8] = data_i;

  assign boundary  = (bcnt_reg == 4'd8);
  assign bcnt_next = boundary ? 4'd0 : bcnt_reg + 4'd1;
  assign ccnt_next = ccnt_reg + 3'd1;
  assign is_comma  = (sr_next == COMMA_SYM);
  assign is_k      = sr_next[8];

  // Alignment / framing state machine with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_HUNT;
      sr_reg    <= '0;
      bcnt_reg  <= '0;
      wcnt_reg  <= '0;
      ccnt_reg  <= '0;
      w0_reg    <= '0;
      w1_reg    <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      locked_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      sr_reg  <= sr_next[8:1];
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state_reg)
        // Bit-granular search: any cycle whose window equals the comma
        // becomes a symbol boundary.
        ST_HUNT: begin
          locked_o <= 1'b0;
          if (is_comma) begin
            bcnt_reg <= 4'd0;
            ccnt_reg <= 3'd1;
            wcnt_reg <= 2'd0;
            if (LOCK_COMMAS == 1) begin
              state_reg <= ST_DATA;
              locked_o  <= 1'b1;
            end else begin
              state_reg <= ST_ALIGN;
            end
          end
        end

        // Candidate alignment: need consecutive commas on boundaries.
        ST_ALIGN: begin
          bcnt_reg <= bcnt_next;
          if (boundary) begin
            if (is_comma) begin
              ccnt_reg <= ccnt_next;
              if (ccnt_next == LOCK_CNT) begin
                state_reg <= ST_DATA;
                wcnt_reg  <= 2'd0;
                locked_o  <= 1'b1;
              end
            end else begin
              state_reg <= ST_HUNT;
              bcnt_reg  <= 4'd0;
              ccnt_reg  <= 3'd0;
              wcnt_reg  <= 2'd0;
            end
          end
        end

        // Locked, collecting the three data symbols of a frame.
        ST_DATA: begin
          bcnt_reg <= bcnt_next;
          if (boundary) begin
            if (is_comma) begin
              // A comma mid-frame drops the partial frame.
              if (wcnt_reg != 2'd0) begin
                err_o <= 1'b1;
              end
              wcnt_reg <= 2'd0;
            end else if (is_k) begin
              err_o     <= 1'b1;
              locked_o  <= 1'b0;
              state_reg <= ST_HUNT;
              bcnt_reg  <= 4'd0;
              ccnt_reg  <= 3'd0;
              wcnt_reg  <= 2'd0;
            end else if (wcnt_reg == 2'd0) begin
              w0_reg   <= sr_next;
              wcnt_reg <= 2'd1;
            end else if (wcnt_reg == 2'd1) begin
              w1_reg   <= sr_next;
              wcnt_reg <= 2'd2;
            end else begin
              data_o    <= {sr_next, w1_reg, w0_reg};
              valid_o   <= 1'b1;
              wcnt_reg  <= 2'd0;
              state_reg <= ST_SYNC;
            end
          end
        end

        // After a complete frame only a comma may follow.
        ST_SYNC: begin
          bcnt_reg <= bcnt_next;
          if (boundary) begin
            if (is_comma) begin
              state_reg <= ST_DATA;
              wcnt_reg  <= 2'd0;
            end else begin
              err_o     <= 1'b1;
              locked_o  <= 1'b0;
              state_reg <= ST_HUNT;
              bcnt_reg  <= 4'd0;
              ccnt_reg  <= 3'd0;
              wcnt_reg  <= 2'd0;
            end
          end
        end

        default: begin
          state_reg <= ST_HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_out.sv
// Testbench for deserializer_out: a bit stream (directed scenarios plus a
// randomized section) is built up front, a symbol-level reference model
// derives the expected events, and a monitor compares DUT outputs each cycle
// against a scoreboard queue filled as the stimulus is issued.
module tb_deserializer_out;

  localparam logic [8:0] C     = 9'h13C;
  localparam int         LOCKN = 2;
  localparam int         MAXN  = 6000;
  localparam int         K_DATA = 1;
  localparam int         K_LOCK = 2;
  localparam int         K_ERR  = 3;

  typedef struct {
    int          edge_i;
    bit          is_valid;
    logic [26:0] data;
  } ev_t;

  typedef struct {
    int          edge_i;
    int          kind;
    logic [26:0] val;
  } mk_t;

  logic        clk;
  logic        rst_i;
  logic        data_i;
  logic [26:0] data_o;
  logic        valid_o;
  logic        locked_o;
  logic        err_o;

  bit          bits_a [MAXN];
  bit          rst_a  [MAXN];
  bit          exp_valid [MAXN];
  bit          exp_err   [MAXN];
  bit          exp_locked[MAXN];
  logic [26:0] exp_data  [MAXN];
  int          n;
  int          cur_edge;
  int          n_cmp;
  int          n_fail;
  ev_t         sbq[$];
  mk_t         mkq[$];
  int          me;
  ev_t         mev;
  mk_t         mmk;

  deserializer_out #(
    .COMMA_SYM  (C),
    .LOCK_COMMAS(LOCKN)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .locked_o(locked_o),
    .err_o   (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%h required=%h", name, e, act, req);
    end
  endtask

  // ---------------- stimulus construction ----------------
  task automatic push_bit(input bit b, input bit r);
    if (n < MAXN) begin
      bits_a[n] = b;
      rst_a[n]  = r;
      n++;
    end
  endtask

  task automatic push_sym(input logic [8:0] s);
    for (int j = 0; j < 9; j++) push_bit(s[j], 1'b0);
  endtask

  task automatic push_rst(input int k);
    for (int j = 0; j < k; j++) push_bit(1'($urandom), 1'b1);
  endtask

  task automatic push_rand(input int k);
    for (int j = 0; j < k; j++) push_bit(1'($urandom), 1'b0);
  endtask

  task automatic mark(input int e, input int kind, input logic [26:0] v);
    mk_t m;
    m.edge_i = e;
    m.kind   = kind;
    m.val    = v;
    mkq.push_back(m);
  endtask

  task automatic frame(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c2,
                       input bit do_mark, input logic [26:0] v);
    int p;
    push_sym(C);
    push_sym(a);
    push_sym(b);
    p = n;
    push_sym(c2);
    if (do_mark) begin
      mark(p + 7, K_DATA, 27'(dut_prev_hold));
      mark(p + 8, K_DATA, v);
    end
  endtask

  logic [26:0] dut_prev_hold;

  task automatic build();
    int p;
    int unsigned r;
    n = 0;
    // S1: reset, idle commas, first frame
    push_rst(3);
    mark(n - 1, K_DATA, 27'h0);
    p = n;
    push_sym(C);
    push_sym(C);
    mark(p + 16, K_LOCK, 27'd0);
    mark(p + 17, K_LOCK, 27'd1);
    push_sym(C);
    push_sym(C);
    dut_prev_hold = 27'h0;
    frame(9'h0A5, 9'h05A, 9'h0FF, 1'b1, 27'h3FCB4A5);
    push_sym(C);
    push_sym(C);
    // S2: arbitrary bit offset before the idle commas
    push_rst(2);
    push_rand(5);
    repeat (4) push_sym(C);
    dut_prev_hold = 27'h0;
    frame(9'h0A5, 9'h05A, 9'h0FF, 1'b1, 27'h3FCB4A5);
    push_sym(C);
    // S3: partial frame cut by a comma, then a good frame
    push_sym(C);
    push_sym(9'h0A5);
    p = n;
    push_sym(C);
    mark(p + 8, K_ERR, 27'd1);
    push_sym(9'h011);
    push_sym(9'h022);
    p = n;
    push_sym(9'h033);
    mark(p + 8, K_DATA, 27'h0CC4411);
    push_sym(C);
    // S4: control symbol inside a frame drops lock
    push_sym(C);
    push_sym(9'h0A5);
    p = n;
    push_sym(9'h1BC);
    mark(p + 8, K_ERR, 27'd1);
    mark(p + 9, K_LOCK, 27'd0);
    p = n;
    push_sym(C);
    push_sym(C);
    mark(p + 16, K_LOCK, 27'd0);
    mark(p + 17, K_LOCK, 27'd1);
    push_sym(C);
    dut_prev_hold = 27'h0CC4411;
    frame(9'h001, 9'h002, 9'h003, 1'b1, 27'h00C0401);
    push_sym(C);
    // S5: reset after word1; word2 must not complete a frame
    push_sym(C);
    push_sym(9'h0A5);
    push_sym(9'h05A);
    push_rst(1);
    mark(n - 1, K_DATA, 27'h0);
    mark(n - 1, K_LOCK, 27'd0);
    push_sym(9'h0FF);
    repeat (3) push_sym(C);
    dut_prev_hold = 27'h0;
    frame(9'h0A5, 9'h05A, 9'h0FF, 1'b1, 27'h3FCB4A5);
    push_sym(C);
    // Randomized section: good frames with occasional faults
    repeat (50) begin
      r = $urandom_range(0, 19);
      if (r == 0) push_rand(int'($urandom_range(1, 8)));
      else if (r == 1) push_sym({1'b1, 8'($urandom)});
      else if (r == 2) begin
        push_sym(C);
        push_sym({1'b0, 8'($urandom)});
      end else if (r == 3) push_rst(int'($urandom_range(1, 3)));
      else if (r == 4) push_sym({1'b0, 8'($urandom)});
      frame({1'b0, 8'($urandom)}, {1'b0, 8'($urandom)}, {1'b0, 8'($urandom)}, 1'b0, 27'h0);
    end
    repeat (3) push_sym(C);
  endtask

  // ---------------- reference model ----------------
  // 9-bit window ending at edge e; bits sampled before the last reset are 0.
  function automatic logic [8:0] window(input int e, input int s);
    logic [8:0] w;
    int idx;
    w = '0;
    for (int j = 0; j < 9; j++) begin
      idx = e - 8 + j;
      w[j] = (idx >= s) ? bits_a[idx] : 1'b0;
    end
    return w;
  endfunction

  // Works symbol by symbol: find a comma anywhere, confirm it on the
  // following symbol slots, then treat the stream as comma + three data
  // symbols, flagging anything that breaks that pattern.
  task automatic run_model();
    int          s;
    int          mode;   // 0 searching, 1 confirming commas, 2 locked
    int          ccnt;
    int          nb;
    bit          need_comma;
    logic [8:0]  pend[$];
    logic [26:0] hold;
    logic [8:0]  sym;
    bit          at_b;
    s = 0; mode = 0; ccnt = 0; nb = 0; need_comma = 0; hold = '0;
    for (int e = 0; e < n; e++) begin
      exp_valid[e] = 1'b0;
      exp_err[e]   = 1'b0;
      if (rst_a[e]) begin
        mode = 0;
        hold = '0;
        s = e + 1;
        exp_locked[e] = 1'b0;
        exp_data[e]   = '0;
        continue;
      end
      sym  = window(e, s);
      at_b = (e == nb);
      if (mode == 0) begin
        if (sym == C) begin
          ccnt = 1;
          nb = e + 9;
          if (ccnt >= LOCKN) begin
            mode = 2;
            pend.delete();
            need_comma = 1'b0;
          end else mode = 1;
        end
      end else if (at_b) begin
        nb = e + 9;
        if (mode == 1) begin
          if (sym == C) begin
            ccnt++;
            if (ccnt >= LOCKN) begin
              mode = 2;
              pend.delete();
              need_comma = 1'b0;
            end
          end else mode = 0;
        end else begin
          if (sym == C) begin
            if (pend.size() != 0) exp_err[e] = 1'b1;
            pend.delete();
            need_comma = 1'b0;
          end else if (sym[8] || need_comma) begin
            exp_err[e] = 1'b1;
            mode = 0;
          end else begin
            pend.push_back(sym);
            if (pend.size() == 3) begin
              hold = {pend[2], pend[1], pend[0]};
              exp_valid[e] = 1'b1;
              pend.delete();
              need_comma = 1'b1;
            end
          end
        end
      end
      exp_locked[e] = (mode == 2);
      exp_data[e]   = hold;
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    ev_t ev;
    n_cmp = 0;
    n_fail = 0;
    cur_edge = -1;
    rst_i = 1'b1;
    data_i = 1'b0;
    build();
    run_model();
    for (int e = 0; e < n; e++) begin
      data_i = bits_a[e];
      rst_i  = rst_a[e];
      if (exp_valid[e] || exp_err[e]) begin
        ev.edge_i   = e;
        ev.is_valid = exp_valid[e];
        ev.data     = exp_data[e];
        sbq.push_back(ev);
      end
      @(posedge clk);
      cur_edge = e;
      #1;
    end
    @(negedge clk);
    #1;
    cur_edge = -1;
    while (sbq.size() > 0) begin
      ev = sbq.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_event edge=%0d actual=none required=%s", ev.edge_i, ev.is_valid ? "valid" : "err");
    end
    while (mkq.size() > 0) begin
      mmk = mkq.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL directed_unreached edge=%0d actual=none required=%h", mmk.edge_i, mmk.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (cur_edge >= 0) begin
      me = cur_edge;
      chk("valid_err_exclusive", me, 32'(valid_o & err_o), 32'd0);
      while (sbq.size() > 0 && sbq[0].edge_i < me) begin
        mev = sbq.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missing_event edge=%0d actual=none required=%s", mev.edge_i, mev.is_valid ? "valid" : "err");
      end
      if (valid_o || err_o) begin
        if (sbq.size() > 0 && sbq[0].edge_i == me) begin
          mev = sbq.pop_front();
          chk("event_kind_valid", me, 32'(valid_o), 32'(mev.is_valid));
          if (mev.is_valid) chk("frame_data", me, 32'(data_o), 32'(mev.data));
          $display("edge %0d: %s data_o=%h locked_o=%0b", me, valid_o ? "valid" : "err", data_o, locked_o);
        end else begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event edge=%0d actual valid=%0b err=%0b required=none", me, valid_o, err_o);
        end
      end
      chk("locked_o", me, 32'(locked_o), 32'(exp_locked[me]));
      chk("data_hold", me, 32'(data_o), 32'(exp_data[me]));
      while (mkq.size() > 0 && mkq[0].edge_i <= me) begin
        mmk = mkq.pop_front();
        if (mmk.kind == K_DATA) chk("directed_data", me, 32'(data_o), 32'(mmk.val));
        else if (mmk.kind == K_LOCK) chk("directed_locked", me, 32'(locked_o), 32'(mmk.val));
        else chk("directed_err", me, 32'(err_o), 32'(mmk.val));
      end
    end
  end

endmodule
